// File: rtl/udp_bank_pkg.sv
// Shared types and next-state function for the UDP latch bank.
// The same next_state() is the reference for any behavioural model of a channel.
package udp_bank_pkg;

  localparam int unsigned MODE_W = 2;
  // Widest channel the shared next-state function can carry; callers zero-extend.
  localparam int unsigned MAX_W  = 64;

  typedef enum logic [MODE_W-1:0] {
    MODE_LATCH  = 2'b00,
    MODE_EDGE   = 2'b01,
    MODE_TOGGLE = 2'b10,
    MODE_HOLD   = 2'b11
  } mode_e;

  // Priority: clr, then the mode-specific update, else hold.
  function automatic logic [MAX_W-1:0] next_state(
    input mode_e            mode,
    input logic             en,
    input logic             en_prev,
    input logic             clr,
    input logic [MAX_W-1:0] d,
    input logic [MAX_W-1:0] q,
    input logic [MAX_W-1:0] rst_val
  );
    logic             rise;
    logic [MAX_W-1:0] nxt;
    rise = en & ~en_prev;
    nxt  = q;
    if (clr) begin
      nxt = rst_val;
    end else begin
      case (mode)
        MODE_LATCH:  if (en)   nxt = d;
        MODE_EDGE:   if (rise) nxt = d;
        MODE_TOGGLE: if (rise) nxt = ~q;
        default:     nxt = q;
      endcase
    end
    return nxt;
  endfunction

endpackage

// File: rtl/udp_latch_chan.sv
// One state channel of the UDP latch bank: q, en history, change pulse and,
// when UDP_BANK_EVT_CNT_EN is defined, a saturating change counter.
module udp_latch_chan
  import udp_bank_pkg::*;
#(
  parameter int unsigned      WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0,
  parameter int unsigned      CNT_W   = 8
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                en_i,
  input  logic [WIDTH-1:0]    d_i,
  input  logic [MODE_W-1:0]   mode_i,
  input  logic                clr_i,
  output logic [WIDTH-1:0]    q_o,
  output logic                changed_o
`ifdef UDP_BANK_EVT_CNT_EN
  ,
  output logic [CNT_W-1:0]    evt_cnt_o
`endif
);

  logic [WIDTH-1:0] q_d, q_q;
  logic             en_prev_q;
  logic             changed_q;
  logic             chg;

  // Next state from the shared function, narrowed back to the channel width.
  always_comb begin
    q_d = WIDTH'(next_state(mode_e'(mode_i), en_i, en_prev_q, clr_i,
                            MAX_W'(d_i), MAX_W'(q_q), MAX_W'(RST_VAL)));
    chg = (q_d != q_q);
  end

  // State, en history (tracked every cycle so a mode switch never re-fires an edge)
  // and the registered change pulse.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q_q       <= RST_VAL;
      en_prev_q <= 1'b0;
      changed_q <= 1'b0;
    end else begin
      q_q       <= q_d;
      en_prev_q <= en_i;
      changed_q <= chg;
    end
  end

  assign q_o       = q_q;
  assign changed_o = changed_q;

`ifdef UDP_BANK_EVT_CNT_EN
  logic [CNT_W-1:0] cnt_d, cnt_q;

  // Saturating count of changes; only reset clears it, clr does not.
  always_comb begin
    cnt_d = cnt_q;
    if (chg && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + 1'b1;
  end

  // Counter register, updated on the same edge that registers changed.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign evt_cnt_o = cnt_q;
`else
  // CNT_W only sizes the counter; keep it referenced when the counter is absent.
  if (CNT_W == 0) begin : g_cnt_w_unused
  end
`endif

endmodule

// File: rtl/udp_latch_bank.sv
// Bank of NCH independent UDP-style state channels (latch / edge / toggle / hold).
// Optional per-channel change counters: define UDP_BANK_EVT_CNT_EN.
module udp_latch_bank
  import udp_bank_pkg::*;
#(
  parameter int unsigned      NCH     = 4,
  parameter int unsigned      WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0,
  parameter int unsigned      CNT_W   = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NCH-1:0]          en,
  input  logic [NCH*WIDTH-1:0]    d,
  input  logic [NCH*MODE_W-1:0]   mode,
  input  logic [NCH-1:0]          clr,
  output logic [NCH*WIDTH-1:0]    q,
  output logic [NCH-1:0]          changed
`ifdef UDP_BANK_EVT_CNT_EN
  ,
  output logic [NCH*CNT_W-1:0]    evt_cnt
`endif
);

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    udp_latch_chan #(
      .WIDTH   (WIDTH),
      .RST_VAL (RST_VAL),
      .CNT_W   (CNT_W)
    ) u_chan (
      .clk_i     (clk),
      .rst_ni    (rst_n),
      .en_i      (en[i]),
      .d_i       (d[i*WIDTH +: WIDTH]),
      .mode_i    (mode[i*MODE_W +: MODE_W]),
      .clr_i     (clr[i]),
      .q_o       (q[i*WIDTH +: WIDTH]),
      .changed_o (changed[i])
`ifdef UDP_BANK_EVT_CNT_EN
      ,
      .evt_cnt_o (evt_cnt[i*CNT_W +: CNT_W])
`endif
    );
  end

endmodule

// File: tb/tb_udp_latch_bank.sv
// Directed self-checking bench for udp_latch_bank (NCH=4, WIDTH=4, CNT_W=2).
module tb_udp_latch_bank;

  localparam int unsigned NCH   = 4;
  localparam int unsigned WIDTH = 4;
  localparam int unsigned CNT_W = 2;

  logic                 clk;
  logic                 rst_n;
  logic [NCH-1:0]       en;
  logic [NCH*WIDTH-1:0] d;
  logic [NCH*2-1:0]     mode;
  logic [NCH-1:0]       clr;
  logic [NCH*WIDTH-1:0] q;
  logic [NCH-1:0]       changed;
`ifdef UDP_BANK_EVT_CNT_EN
  logic [NCH*CNT_W-1:0] evt_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  udp_latch_bank #(
    .NCH     (NCH),
    .WIDTH   (WIDTH),
    .RST_VAL (4'h0),
    .CNT_W   (CNT_W)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .d       (d),
    .mode    (mode),
    .clr     (clr),
    .q       (q),
    .changed (changed)
`ifdef UDP_BANK_EVT_CNT_EN
    ,
    .evt_cnt (evt_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] qch(input int ch);
    return 32'(q[ch*WIDTH +: WIDTH]);
  endfunction

  function automatic logic [31:0] chg(input int ch);
    return 32'(changed[ch]);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_ch(input int ch, input logic [1:0] m, input logic e,
                        input logic [3:0] dv, input logic c);
    mode[2*ch +: 2]     = m;
    en[ch]              = e;
    d[ch*WIDTH +: WIDTH] = dv;
    clr[ch]             = c;
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b1;
    en    = '0;
    d     = '0;
    mode  = {NCH{2'b11}};
    clr   = '0;
    #1 rst_n = 1'b0;
    #1;
    chk("reset_q", 32'(q), 0);
    chk("reset_changed", 32'(changed), 0);
    step();
    step();
    rst_n = 1'b1;
    step();
    chk("reset_exit_changed", 32'(changed), 0);

    // LATCH then hold on channel 0
    set_ch(0, 2'b00, 1'b1, 4'h1, 1'b0);
    step();
    chk("latch_q", qch(0), 1);
    chk("latch_changed", chg(0), 1);
    set_ch(0, 2'b00, 1'b0, 4'h0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("hold_q", qch(0), 1);
      chk("hold_changed", chg(0), 0);
    end

    // EDGE on channel 1: capture only on en rise
    set_ch(1, 2'b01, 1'b1, 4'h3, 1'b0);
    step();
    chk("edge_first_q", qch(1), 3);
    chk("edge_first_changed", chg(1), 1);
    d[1*WIDTH +: WIDTH] = 4'h5;
    step();
    chk("edge_high_q5", qch(1), 3);
    chk("edge_high_changed", chg(1), 0);
    d[1*WIDTH +: WIDTH] = 4'h7;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("edge_high_q7", qch(1), 3);
    end
    en[1] = 1'b0;
    step();
    chk("edge_low_q", qch(1), 3);
    en[1] = 1'b1;
    step();
    chk("edge_rerise_q", qch(1), 7);
    chk("edge_rerise_changed", chg(1), 1);

    // TOGGLE on channel 2: pulses give F,0,F; held en gives nothing more
    set_ch(2, 2'b10, 1'b1, 4'h0, 1'b0);
    step();
    chk("tog1_q", qch(2), 4'hF);
    chk("tog1_changed", chg(2), 1);
    en[2] = 1'b0;
    step();
    chk("tog1_low_changed", chg(2), 0);
    en[2] = 1'b1;
    step();
    chk("tog2_q", qch(2), 4'h0);
    chk("tog2_changed", chg(2), 1);
    en[2] = 1'b0;
    step();
    en[2] = 1'b1;
    step();
    chk("tog3_q", qch(2), 4'hF);
    chk("tog3_changed", chg(2), 1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("tog_held_q", qch(2), 4'hF);
      chk("tog_held_changed", chg(2), 0);
    end
    // Two more toggles: five changes total on channel 2 -> F,0,F,0,F
    en[2] = 1'b0;
    step();
    en[2] = 1'b1;
    step();
    chk("tog4_q", qch(2), 4'h0);
    en[2] = 1'b0;
    step();
    en[2] = 1'b1;
    step();
    chk("tog5_q", qch(2), 4'hF);
`ifdef UDP_BANK_EVT_CNT_EN
    chk("evt_cnt_sat", 32'(evt_cnt[2*CNT_W +: CNT_W]), 3);
`endif
    set_ch(2, 2'b10, 1'b1, 4'h0, 1'b1);
    step();
    chk("tog_clr_q", qch(2), 0);
    chk("tog_clr_changed", chg(2), 1);
`ifdef UDP_BANK_EVT_CNT_EN
    chk("evt_cnt_clr_kept", 32'(evt_cnt[2*CNT_W +: CNT_W]), 3);
`endif
    clr[2] = 1'b0;
    step();
    chk("tog_after_clr_q", qch(2), 0);

    // Priority: clr beats LATCH on ch0; ch1 latches 9 in the same cycle
    set_ch(0, 2'b00, 1'b1, 4'h5, 1'b1);
    set_ch(1, 2'b00, 1'b1, 4'h9, 1'b0);
    step();
    chk("prio_clr_q0", qch(0), 0);
    chk("prio_clr_changed0", chg(0), 1);
    chk("indep_q1", qch(1), 9);
    chk("indep_changed1", chg(1), 1);
    step();
    chk("clr_at_rst_val_changed0", chg(0), 0);
    chk("latch_const_changed1", chg(1), 0);
    clr[0] = 1'b0;

    // Mode switch with en held high must not re-detect an edge
    set_ch(3, 2'b01, 1'b1, 4'h6, 1'b0);
    step();
    chk("sw_edge_q", qch(3), 6);
    mode[2*3 +: 2] = 2'b10;
    step();
    chk("sw_toggle_no_edge_q", qch(3), 6);
    chk("sw_toggle_no_edge_changed", chg(3), 0);

    // Async reset mid-run with q=A on ch3
    set_ch(3, 2'b00, 1'b1, 4'hA, 1'b0);
    step();
    chk("pre_rst_q3", qch(3), 4'hA);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_q", 32'(q), 0);
    chk("midrst_changed", 32'(changed), 0);
`ifdef UDP_BANK_EVT_CNT_EN
    chk("midrst_evt_cnt", 32'(evt_cnt), 0);
`endif
    en   = '0;
    clr  = '0;
    mode = {NCH{2'b11}};
    step();
    chk("rst_held_q", 32'(q), 0);
    rst_n = 1'b1;
    step();
    chk("rst_exit_changed", 32'(changed), 0);
    chk("rst_exit_q", 32'(q), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
